// File: rtl/all_eight_bits_set.sv
//------------------------------------------------------------------------------
// Module      : all_eight_bits_set
// Description : Registered all-set / any-set / popcount qualifier for a vector,
//               with a one-cycle pulse on the rising edge of the all-set flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module all_eight_bits_set #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic             all_set,
    output logic             any_set,
    output logic [CNT_W-1:0] set_count,
    output logic             all_set_rise
);

    logic             all_set_d,      all_set_q;
    logic             any_set_d,      any_set_q;
    logic [CNT_W-1:0] set_count_d,    set_count_q;
    logic             all_set_rise_d, all_set_rise_q;

    always_comb begin
        all_set_d   = &in;
        any_set_d   = |in;
        set_count_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            set_count_d = set_count_d + CNT_W'(in[i]);
        end
        // Compare against the registered flag so a held all-ones input pulses once.
        all_set_rise_d = all_set_d & ~all_set_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            all_set_q      <= 1'b0;
            any_set_q      <= 1'b0;
            set_count_q    <= '0;
            all_set_rise_q <= 1'b0;
        end else begin
            all_set_q      <= all_set_d;
            any_set_q      <= any_set_d;
            set_count_q    <= set_count_d;
            all_set_rise_q <= all_set_rise_d;
        end
    end

    assign all_set      = all_set_q;
    assign any_set      = any_set_q;
    assign set_count    = set_count_q;
    assign all_set_rise = all_set_rise_q;

endmodule

`default_nettype wire

// File: tb/tb_all_eight_bits_set.sv
//------------------------------------------------------------------------------
// Module      : tb_all_eight_bits_set
// Description : Directed self-checking bench for all_eight_bits_set.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_all_eight_bits_set;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       all_set;
    logic       any_set;
    logic [3:0] set_count;
    logic       all_set_rise;

    int passed;
    int total;

    all_eight_bits_set #(.WIDTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in           (in),
        .all_set      (all_set),
        .any_set      (any_set),
        .set_count    (set_count),
        .all_set_rise (all_set_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector before a rising edge, then let outputs settle after it.
    task automatic step(input logic [7:0] v, input logic r);
        @(negedge clk);
        in    = v;
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic e_all, input logic e_any,
                           input logic [3:0] e_cnt, input logic e_rise);
        chk({tag, ".all_set"},      {3'b0, all_set},      {3'b0, e_all});
        chk({tag, ".any_set"},      {3'b0, any_set},      {3'b0, e_any});
        chk({tag, ".set_count"},    set_count,            e_cnt);
        chk({tag, ".all_set_rise"}, {3'b0, all_set_rise}, {3'b0, e_rise});
    endtask

    initial begin
        logic [7:0] walk;
        logic       prev_all;
        logic       e_all;
        logic [3:0] e_cnt;
        passed = 0;
        total  = 0;
        in     = 8'h00;
        rst_n  = 1'b0;

        // Reset held two cycles with all-ones applied
        step(8'hFF, 1'b0);
        chk_all("rst0", 1'b0, 1'b0, 4'd0, 1'b0);
        step(8'hFF, 1'b0);
        chk_all("rst1", 1'b0, 1'b0, 4'd0, 1'b0);
        step(8'hFF, 1'b1);
        chk_all("rel_ff", 1'b1, 1'b1, 4'd8, 1'b1);
        step(8'hFF, 1'b1);
        chk_all("hold_ff", 1'b1, 1'b1, 4'd8, 1'b0);

        // Directed sequence
        step(8'hFF, 1'b1); chk_all("seq_ff", 1'b1, 1'b1, 4'd8, 1'b0);
        step(8'hFE, 1'b1); chk_all("seq_fe", 1'b0, 1'b1, 4'd7, 1'b0);
        step(8'hAA, 1'b1); chk_all("seq_aa", 1'b0, 1'b1, 4'd4, 1'b0);
        step(8'h00, 1'b1); chk_all("seq_00", 1'b0, 1'b0, 4'd0, 1'b0);
        step(8'hC3, 1'b1); chk_all("seq_c3", 1'b0, 1'b1, 4'd4, 1'b0);

        // Toggle between 0xFE and 0xFF
        step(8'hFE, 1'b1); chk_all("alt0", 1'b0, 1'b1, 4'd7, 1'b0);
        step(8'hFF, 1'b1); chk_all("alt1", 1'b1, 1'b1, 4'd8, 1'b1);
        step(8'hFE, 1'b1); chk_all("alt2", 1'b0, 1'b1, 4'd7, 1'b0);
        step(8'hFF, 1'b1); chk_all("alt3", 1'b1, 1'b1, 4'd8, 1'b1);

        // Walking single zero
        walk = 8'h7F;
        for (int i = 0; i < 8; i++) begin
            step(walk, 1'b1);
            chk_all($sformatf("walk_%02h", walk), 1'b0, 1'b1, 4'd7, 1'b0);
            walk = {1'b1, walk[7:1]};
        end

        // Mid-operation reset while all-ones is held
        step(8'hFF, 1'b1); chk_all("pre_ff", 1'b1, 1'b1, 4'd8, 1'b1);
        step(8'hFF, 1'b1); chk_all("pre_hold", 1'b1, 1'b1, 4'd8, 1'b0);
        step(8'hFF, 1'b0); chk_all("mid_rst", 1'b0, 1'b0, 4'd0, 1'b0);
        step(8'hFF, 1'b1); chk_all("mid_rel", 1'b1, 1'b1, 4'd8, 1'b1);

        // Exhaustive sweep with a bench-side popcount and rise model
        prev_all = 1'b1;
        for (int v = 0; v < 256; v++) begin
            e_cnt = 4'd0;
            for (int b = 0; b < 8; b++) begin
                if (((v >> b) & 1) != 0) e_cnt = e_cnt + 4'd1;
            end
            e_all = (v == 255);
            step(8'(v), 1'b1);
            chk_all($sformatf("sweep_%02h", v), e_all, (v != 0), e_cnt, e_all & ~prev_all);
            chk($sformatf("inv_all_%02h", v), {3'b0, all_set}, {3'b0, (set_count == 4'd8)});
            chk($sformatf("inv_any_%02h", v), {3'b0, any_set}, {3'b0, (set_count != 4'd0)});
            prev_all = e_all;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
